rv_inst_encoder: RTL

- Streaming RV32I instruction encoder, the inverse of the core's control decode path.
- Accepts abstract micro-op requests using the same encodings the control path produces: instruction class, 4-bit ALU op, 3-bit branch type, register indices and immediate.
- Emits legal 32-bit RV32I words, each tagged with a sequential instruction-memory byte address.
- Sits between the self-test/boot sequencer and the instruction-memory write port; buffers output in a small FIFO.

---
 rtl/rv_isa_pkg.sv | 165 ++++++++++++++++
 rtl/rv_inst_encoder_sync_fifo.sv | 62 ++++++
 rtl/rv_inst_encoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rv_isa_pkg.sv
`default_nettype none
// ============================================================================
// rv_isa_pkg : RV32I opcodes, control-path class/op encodings, immediate
//              ranges and the combinational micro-op -> instruction encoder.
// Revision   : 1.0
// ============================================================================
package rv_isa_pkg;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    typedef enum logic [3:0] {
        CLS_R     = 4'd0,
        CLS_I_ALU = 4'd1,
        CLS_LOAD  = 4'd2,
        CLS_STORE = 4'd3,
        CLS_BR    = 4'd4,
        CLS_LUI   = 4'd5,
        CLS_AUIPC = 4'd6,
        CLS_JAL   = 4'd7,
        CLS_JALR  = 4'd8
    } inst_cls_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SRA  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    typedef struct packed {
        logic        legal;
        logic [31:0] inst;
    } enc_res_t;

    function automatic logic [2:0] alu_f3(input logic [3:0] op);
        logic [2:0] f3;
        case (op)
            ALU_SLL:  f3 = 3'b001;
            ALU_SLT:  f3 = 3'b010;
            ALU_SLTU: f3 = 3'b011;
            ALU_XOR:  f3 = 3'b100;
            ALU_SRL:  f3 = 3'b101;
            ALU_SRA:  f3 = 3'b101;
            ALU_OR:   f3 = 3'b110;
            ALU_AND:  f3 = 3'b111;
            default:  f3 = 3'b000;
        endcase
        return f3;
    endfunction

    function automatic logic [6:0] alu_f7(input logic [3:0] op);
        return (op == ALU_SUB || op == ALU_SRA) ? 7'b0100000 : 7'b0000000;
    endfunction

    function automatic logic [2:0] br_f3(input logic [2:0] bt);
        logic [2:0] f3;
        case (bt)
            BR_BNE:  f3 = 3'b001;
            BR_BLT:  f3 = 3'b100;
            BR_BGE:  f3 = 3'b101;
            BR_BLTU: f3 = 3'b110;
            BR_BGEU: f3 = 3'b111;
            default: f3 = 3'b000;
        endcase
        return f3;
    endfunction

    function automatic enc_res_t rv_encode(
        input logic [3:0]  cls,
        input logic [3:0]  alu_op,
        input logic [2:0]  br_type,
        input logic [2:0]  mem_f3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        enc_res_t          r;
        logic signed [31:0] s;
        logic              in_i;
        r.legal = 1'b0;
        r.inst  = 32'h0;
        s       = $signed(imm);
        in_i    = (s >= IMM_I_MIN) && (s <= IMM_I_MAX);
        case (cls)
            CLS_R: begin
                r.legal = (alu_op <= ALU_AND);
                r.inst  = {alu_f7(alu_op), rs2, rs1, alu_f3(alu_op), rd, OPC_OP};
            end
            CLS_I_ALU: begin
                // Shifts carry shamt in the rs2 slot, so their range is 0..31
                if (alu_op == ALU_SLL || alu_op == ALU_SRL || alu_op == ALU_SRA) begin
                    r.legal = (imm[31:5] == 27'h0);
                    r.inst  = {alu_f7(alu_op), imm[4:0], rs1, alu_f3(alu_op), rd, OPC_OP_IMM};
                end else begin
                    r.legal = (alu_op <= ALU_AND) && (alu_op != ALU_SUB) && in_i;
                    r.inst  = {imm[11:0], rs1, alu_f3(alu_op), rd, OPC_OP_IMM};
                end
            end
            CLS_LOAD: begin
                r.legal = in_i;
                r.inst  = {imm[11:0], rs1, mem_f3, rd, OPC_LOAD};
            end
            CLS_STORE: begin
                r.legal = in_i;
                r.inst  = {imm[11:5], rs2, rs1, mem_f3, imm[4:0], OPC_STORE};
            end
            CLS_BR: begin
                r.legal = (br_type >= BR_BEQ) && (br_type <= BR_BGEU) && !imm[0]
                          && (s >= IMM_B_MIN) && (s <= IMM_B_MAX);
                r.inst  = {imm[12], imm[10:5], rs2, rs1, br_f3(br_type),
                           imm[4:1], imm[11], OPC_BRANCH};
            end
            CLS_LUI: begin
                r.legal = (imm[31:20] == 12'h0);
                r.inst  = {imm[19:0], rd, OPC_LUI};
            end
            CLS_AUIPC: begin
                r.legal = (imm[31:20] == 12'h0);
                r.inst  = {imm[19:0], rd, OPC_AUIPC};
            end
            CLS_JAL: begin
                r.legal = !imm[0] && (s >= IMM_J_MIN) && (s <= IMM_J_MAX);
                r.inst  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            end
            CLS_JALR: begin
                r.legal = in_i;
                r.inst  = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            end
            default: begin
                r.legal = 1'b0;
                r.inst  = 32'h0;
            end
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_inst_encoder_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with registered storage and simultaneous
//             push/pop when full. Head word is held stable until popped.
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]    count_q,  count_d;
    logic             w_push, w_pop;

    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == c_FULL);
        w_pop    = pop_i && !empty_o;
        w_push   = push_i && (!full_o || w_pop);
        wr_ptr_d = wr_ptr_q + c_AW'(w_push);
        rd_ptr_d = rd_ptr_q + c_AW'(w_pop);
        count_d  = count_q + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
        rdata_o  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv_inst_encoder.sv
`default_nettype none
// ============================================================================
// rv_inst_encoder : streaming RV32I micro-op encoder with address stamping,
//                   illegal-request dropping and an output FIFO.
//                   RV_INST_ENC_STATS_EN adds enc_cnt/stall_cnt outputs.
// Revision        : 1.0
// ============================================================================
module rv_inst_encoder
    import rv_isa_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cls,
    input  logic [3:0]  in_alu_op,
    input  logic [2:0]  in_br_type,
    input  logic [2:0]  in_mem_f3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_cnt
`ifdef RV_INST_ENC_STATS_EN
    ,
    output logic [15:0] enc_cnt,
    output logic [15:0] stall_cnt
`endif
);

    enc_res_t    w_enc;
    logic        w_pop, w_full, w_empty, w_can_push, w_s1_push;
    logic        w_accept, w_load, w_drop;
    logic [63:0] w_fifo_rdata;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_inst_q,  s1_inst_d;
    logic [31:0] s1_addr_q,  s1_addr_d;
    logic [31:0] addr_q,     addr_d;
    logic        err_q,      err_d;
    logic [7:0]  err_cnt_q,  err_cnt_d;

    always_comb begin
        w_enc      = rv_encode(in_cls, in_alu_op, in_br_type, in_mem_f3,
                               in_rd, in_rs1, in_rs2, in_imm);
        w_pop      = out_valid && out_ready;
        w_can_push = !w_full || w_pop;
        w_s1_push  = s1_valid_q && w_can_push;
        in_ready   = rst_n && !flush && (!s1_valid_q || w_can_push);
        w_accept   = in_valid && in_ready;
        w_load     = w_accept && w_enc.legal;
        w_drop     = w_accept && !w_enc.legal;

        s1_valid_d = s1_valid_q && !w_s1_push;
        s1_inst_d  = s1_inst_q;
        s1_addr_d  = s1_addr_q;
        addr_d     = addr_q;
        if (w_load) begin
            s1_valid_d = 1'b1;
            s1_inst_d  = w_enc.inst;
            s1_addr_d  = addr_q;
            addr_d     = addr_q + 32'd4;
        end
        err_d     = w_drop;
        err_cnt_d = (w_drop && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_inst_q  <= 32'h0;
            s1_addr_q  <= 32'h0;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'h0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_inst_q  <= s1_inst_d;
            s1_addr_q  <= s1_addr_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (w_s1_push),
        .pop_i   (w_pop),
        .wdata_i ({s1_addr_q, s1_inst_q}),
        .rdata_o (w_fifo_rdata),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    assign out_valid = !w_empty;
    assign out_addr  = w_fifo_rdata[63:32];
    assign out_inst  = w_fifo_rdata[31:0];
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

`ifdef RV_INST_ENC_STATS_EN
    logic [15:0] enc_cnt_q, stall_cnt_q;

    // Statistics survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_cnt_q   <= 16'h0;
            stall_cnt_q <= 16'h0;
        end else begin
            if (w_pop && enc_cnt_q != 16'hFFFF) begin
                enc_cnt_q <= enc_cnt_q + 16'd1;
            end
            if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign enc_cnt   = enc_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
